nios_wr_sequencer: RTL and testbench

//  Avalon-MM slave on the Nios bus that sequences block writes into the on-chip RAM write port.

---
 rtl/nios_wr_seq_pkg.sv | 26 ++
 rtl/nios_wr_sequencer_if.sv | 26 ++
 rtl/nios_wr_seq_fifo.sv | 61 ++++++
 rtl/nios_wr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_nios_wr_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/nios_wr_seq_pkg.sv
// Shared definitions for the Nios block-write sequencer: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package nios_wr_seq_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_BASE   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_IE        = 2;
    localparam int CTRL_COUNT_LSB = 16;

    localparam int STS_BUSY  = 0;
    localparam int STS_EMPTY = 1;
    localparam int STS_FULL  = 2;
    localparam int STS_OVF   = 3;
    localparam int STS_DONE  = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/nios_wr_sequencer_if.sv
// Avalon-MM slave bus bundle between the Nios interconnect and the sequencer.
interface nios_wr_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

endinterface

// File: rtl/nios_wr_seq_fifo.sv
// Small synchronous FIFO with show-ahead head; a push into a full FIFO
// succeeds only when a pop happens on the same edge.
module nios_wr_seq_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/nios_wr_sequencer.sv
// Avalon-MM slave that streams FIFO-buffered words into a RAM write port,
// one word per clock from a software-loaded base address.
module nios_wr_sequencer
    import nios_wr_seq_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    nios_wr_sequencer_if.slave bus,
    output logic [ADDR_W-1:0]  wraddress,
    output logic [DATA_W-1:0]  wrdata,
    output logic               wren,
    output logic               irq
);

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              ie_q, ie_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] wraddress_q, wraddress_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              wren_q, wren_d;

    logic              bus_wr, data_wr, base_wr, ctrl_wr, status_wr;
    logic              ctrl_start, ctrl_abort;
    logic [ADDR_W-1:0] ctrl_count;
    logic              pop, done_set, ovf_set;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_empty, fifo_full;
    logic [31:0]       readdata_c;
    logic              writedata_unused;

    assign bus_wr     = bus.chipselect & ~bus.write_n;
    assign data_wr    = bus_wr && (bus.address == REG_DATA);
    assign base_wr    = bus_wr && (bus.address == REG_BASE);
    assign ctrl_wr    = bus_wr && (bus.address == REG_CTRL);
    assign status_wr  = bus_wr && (bus.address == REG_STATUS);
    assign ctrl_start = ctrl_wr & bus.writedata[CTRL_START];
    assign ctrl_abort = ctrl_wr & bus.writedata[CTRL_ABORT];
    assign ctrl_count = bus.writedata[CTRL_COUNT_LSB +: ADDR_W];
    assign writedata_unused = ^bus.writedata;

    // An abort in the same cycle suppresses the pop so no word leaks out.
    assign pop = (state_q == S_RUN) & ~fifo_empty & ~ctrl_abort;

    nios_wr_seq_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (data_wr),
        .pop     (pop),
        .flush   (ctrl_abort),
        .din     (bus.writedata[DATA_W-1:0]),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        ie_d        = ie_q;
        wraddress_d = wraddress_q;
        wrdata_d    = wrdata_q;
        wren_d      = 1'b0;
        done_set    = 1'b0;
        ovf_set     = data_wr & fifo_full & ~pop;

        if (pop) begin
            wren_d      = 1'b1;
            wraddress_d = ptr_q;
            wrdata_d    = fifo_head;
            ptr_d       = ptr_q + A_ONE;
            remaining_d = remaining_q - A_ONE;
            if (remaining_q == A_ONE) begin
                state_d  = S_IDLE;
                done_set = 1'b1;
            end
        end

        if (base_wr && (state_q == S_IDLE)) ptr_d = bus.writedata[ADDR_W-1:0];

        if (ctrl_wr) ie_d = bus.writedata[CTRL_IE];

        if (ctrl_abort) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end else if (ctrl_start && (state_q == S_IDLE)) begin
            if (ctrl_count != '0) begin
                state_d     = S_RUN;
                remaining_d = ctrl_count;
            end else begin
                done_set = 1'b1;
            end
        end

        // Sticky flags: a set on the same edge beats a software clear.
        done_d = (done_q & ~(status_wr & bus.writedata[STS_DONE])) | done_set;
        ovf_d  = (ovf_q  & ~(status_wr & bus.writedata[STS_OVF]))  | ovf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            ie_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            wraddress_q <= '0;
            wrdata_q    <= '0;
            wren_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            ie_q        <= ie_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            wraddress_q <= wraddress_d;
            wrdata_q    <= wrdata_d;
            wren_q      <= wren_d;
        end
    end

    always_comb begin
        readdata_c = '0;
        case (bus.address)
            REG_BASE: readdata_c[ADDR_W-1:0] = ptr_q;
            REG_CTRL: begin
                readdata_c[CTRL_COUNT_LSB +: ADDR_W] = remaining_q;
                readdata_c[CTRL_IE]                  = ie_q;
            end
            REG_STATUS: begin
                readdata_c[STS_BUSY]  = (state_q == S_RUN);
                readdata_c[STS_EMPTY] = fifo_empty;
                readdata_c[STS_FULL]  = fifo_full;
                readdata_c[STS_OVF]   = ovf_q;
                readdata_c[STS_DONE]  = done_q;
            end
            default: readdata_c = '0;
        endcase
    end

    assign bus.readdata = readdata_c;
    assign wraddress    = wraddress_q;
    assign wrdata       = wrdata_q;
    assign wren         = wren_q;
    assign irq          = done_q & ie_q;

endmodule

// File: tb/tb_nios_wr_sequencer.sv
// Directed bench: stimulus queues expected RAM writes, a negedge monitor
// pops and compares every wren pulse; register reads are checked inline.
module tb_nios_wr_sequencer;
    import nios_wr_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] wraddress;
    logic [31:0] wrdata;
    logic        wren;
    logic        irq;

    nios_wr_sequencer_if bus();

    nios_wr_sequencer #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .wraddress (wraddress),
        .wrdata    (wrdata),
        .wren      (wren),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s: 0x%0h ok", name, act);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (reset_n && wren) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", wraddress, wrdata);
            end else begin
                e = sb.pop_front();
                if (wraddress !== e.a || wrdata !== e.d) begin
                    errors++;
                    $display("FAIL ram_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             wraddress, wrdata, e.a, e.d);
                end else begin
                    $display("write addr 0x%0h data 0x%0h ok", wraddress, wrdata);
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        chk(name, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_wren", {31'd0, wren}, 32'd0);
        chk("rst_wraddress", {20'd0, wraddress}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        bus_read(REG_STATUS, 32'h02, "rst_status");
        bus_read(REG_BASE, 32'h0, "rst_base");

        // 1: preload three words, then start
        bus_write(REG_BASE, 32'h010);
        bus_write(REG_DATA, 32'hAAAA_0001);
        bus_write(REG_DATA, 32'hBBBB_0002);
        bus_write(REG_DATA, 32'hCCCC_0003);
        chk("t1_no_wren_idle", {31'd0, wren}, 32'd0);
        expect_wr(12'h010, 32'hAAAA_0001);
        expect_wr(12'h011, 32'hBBBB_0002);
        expect_wr(12'h012, 32'hCCCC_0003);
        bus_write(REG_CTRL, 32'h0003_0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t1_wren_clk%0d", i), {31'd0, wren}, 32'd1);
        end
        @(negedge clk);
        chk("t1_wren_end", {31'd0, wren}, 32'd0);
        drain("t1_drain");
        bus_read(REG_STATUS, 32'h12, "t1_status");
        bus_read(REG_BASE, 32'h013, "t1_base");
        bus_write(REG_STATUS, 32'h10);

        // 2: start first, then feed words across the address wrap
        bus_write(REG_BASE, 32'hFFE);
        bus_write(REG_CTRL, 32'h0004_0001);
        bus_read(REG_STATUS, 32'h03, "t2_busy_empty");
        for (int i = 0; i < 4; i++) begin
            logic [11:0] a;
            a = 12'hFFE + 12'(i);
            expect_wr(a, 32'h2000_0000 + 32'(i));
            bus_write(REG_DATA, 32'h2000_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("t2_latency%0d", i), {31'd0, wren}, 32'd1);
        end
        drain("t2_drain");
        bus_read(REG_STATUS, 32'h12, "t2_status");
        bus_read(REG_BASE, 32'h002, "t2_base");
        bus_write(REG_STATUS, 32'h10);

        // 3: overflow while idle, clear OVF, then write the first eight
        for (int i = 0; i < 9; i++) bus_write(REG_DATA, 32'h3000_0000 + 32'(i));
        chk("t3_no_wren", {31'd0, wren}, 32'd0);
        bus_read(REG_STATUS, 32'h0C, "t3_full_ovf");
        bus_write(REG_STATUS, 32'h08);
        bus_read(REG_STATUS, 32'h04, "t3_ovf_clr");
        bus_write(REG_BASE, 32'h200);
        for (int i = 0; i < 8; i++) expect_wr(12'h200 + 12'(i), 32'h3000_0000 + 32'(i));
        bus_write(REG_CTRL, 32'h0008_0001);
        drain("t3_drain");
        bus_read(REG_STATUS, 32'h12, "t3_status");
        bus_write(REG_STATUS, 32'h10);

        // 4: abort after two of five words
        bus_write(REG_BASE, 32'h300);
        bus_write(REG_CTRL, 32'h0005_0001);
        expect_wr(12'h300, 32'h4000_0000);
        bus_write(REG_DATA, 32'h4000_0000);
        expect_wr(12'h301, 32'h4000_0001);
        bus_write(REG_DATA, 32'h4000_0001);
        bus_read(REG_CTRL, 32'h0003_0000, "t4_remaining");
        bus_write(REG_CTRL, 32'h0000_0002);
        chk("t4_wren_off", {31'd0, wren}, 32'd0);
        bus_read(REG_STATUS, 32'h02, "t4_status");
        bus_read(REG_CTRL, 32'h0, "t4_ctrl");
        bus_read(REG_BASE, 32'h302, "t4_base_kept");
        drain("t4_drain");

        // 5: zero-count start raises DONE/irq; BASE ignored while running
        bus_write(REG_CTRL, 32'h0000_0005);
        chk("t5_irq_set", {31'd0, irq}, 32'd1);
        bus_read(REG_STATUS, 32'h12, "t5_status");
        bus_write(REG_STATUS, 32'h10);
        chk("t5_irq_clr", {31'd0, irq}, 32'd0);
        bus_read(REG_CTRL, 32'h4, "t5_ctrl_ie");
        bus_write(REG_CTRL, 32'h0002_0005);
        bus_write(REG_BASE, 32'h777);
        bus_read(REG_BASE, 32'h302, "t5_base_run");
        expect_wr(12'h302, 32'h5000_0000);
        bus_write(REG_DATA, 32'h5000_0000);
        expect_wr(12'h303, 32'h5000_0001);
        bus_write(REG_DATA, 32'h5000_0001);
        drain("t5_drain");
        chk("t5_irq_done", {31'd0, irq}, 32'd1);
        bus_write(REG_STATUS, 32'h10);
        chk("t5_irq_clr2", {31'd0, irq}, 32'd0);

        // 6: reset asserted while the second word's pulse is on the bus
        bus_write(REG_BASE, 32'h020);
        bus_write(REG_CTRL, 32'h0004_0001);
        expect_wr(12'h020, 32'h6000_0000);
        bus_write(REG_DATA, 32'h6000_0000);
        @(negedge clk);
        chk("t6_first_write", {31'd0, wren}, 32'd1);
        bus_write(REG_DATA, 32'h6000_0001);
        @(posedge clk);
        #1;
        chk("t6_inflight", {31'd0, wren}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_wren_cut", {31'd0, wren}, 32'd0);
        chk("t6_wraddress", {20'd0, wraddress}, 32'd0);
        chk("t6_wrdata", wrdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(REG_BASE, 32'h0, "t6_base");
        bus_read(REG_STATUS, 32'h02, "t6_status");
        bus_read(REG_CTRL, 32'h0, "t6_ctrl");
        repeat (3) @(negedge clk);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
